// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial two's-complement adder/subtractor. One bit is
//                processed per clock, LSB first, through a single full-adder
//                / full-subtractor cell. The carry (add) or borrow (sub) is
//                held in a flip-flop between bits. Start/busy/done handshake.
//
//  Ports       : clk    - rising-edge clock
//                rst    - synchronous active-high reset
//                start  - request an operation (accepted in IDLE or DONE)
//                mode   - 0 = a+b, 1 = a-b (latched at accepted start)
//                a, b   - operands (latched at accepted start)
//                busy   - high while bits are being processed
//                done   - one-cycle pulse, result and flags valid
//                result - sum/difference, held until the next accepted start
//                cout   - carry-out (add) or borrow-out (sub) of the MSB
//                ovf    - signed two's-complement overflow
//
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int               c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [c_CW-1:0]  r_cnt;
    logic             r_c;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_ai;
    logic             w_bi;
    logic             w_s;
    logic             w_c_nxt;
    logic             w_msb_same;
    logic             w_ovf;

    // Start is only honoured when no operation is in flight.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == c_LAST);

    // Single-bit arithmetic cell on the latched operands.
    assign w_ai = r_a[r_cnt];
    assign w_bi = r_b[r_cnt];
    assign w_s  = w_ai ^ w_bi ^ r_c;

    always_comb begin
        w_c_nxt = 1'b0;
        if (r_mode) begin
            // Borrow: subtrahend bit exceeds minuend bit, or equal bits with
            // an incoming borrow.
            w_c_nxt = (~w_ai & w_bi) | (r_c & ~(w_ai ^ w_bi));
        end else begin
            w_c_nxt = (w_ai & w_bi) | (r_c & (w_ai ^ w_bi));
        end
    end

    // Overflow is evaluated in the last RUN cycle, where w_s is the final
    // result MSB.
    assign w_msb_same = (r_a[WIDTH-1] == r_b[WIDTH-1]);
    assign w_ovf      = (r_mode ? ~w_msb_same : w_msb_same) &
                        (w_s != r_a[WIDTH-1]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = w_accept ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_mode <= mode;
            r_cnt  <= '0;
            r_c    <= 1'b0;
        end else if (r_state == ST_RUN) begin
            // Shift in from the MSB side; after WIDTH shifts bit 0 lands at
            // result[0].
            r_result <= {w_s, r_result[WIDTH-1:1]};
            r_c      <= w_c_nxt;
            r_cnt    <= r_cnt + c_ONE;
            if (w_last) begin
                r_cout <= w_c_nxt;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Self-checking bench for serial_addsub (WIDTH = 8). Expected
//                results are queued when an operation is launched and popped
//                when the matching done pulse appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_run  = 0;
    int n_fail = 0;

    exp_t sb[$];

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: plain wide arithmetic.
    function automatic exp_t model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        exp_t       e;
        if (m) t = {1'b0, x} - {1'b0, y};
        else   t = {1'b0, x} + {1'b0, y};
        e.res  = t[W-1:0];
        e.cout = t[W];
        if (m) e.ovf = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
        else   e.ovf = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    // Called right after a negedge: drive a start request and queue the
    // expected outcome.
    task automatic launch(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        mode  = m;
        a     = x;
        b     = y;
        sb.push_back(model(m, x, y));
    endtask

    // Step negedges until done is seen (bounded). start is dropped after the
    // first step. cyc counts cycles since the start edge.
    task automatic wait_done(output int cyc, output int bcnt, output bit to);
        cyc  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (busy) bcnt++;
        end while (!done && cyc < 40);
        to = !done;
    endtask

    task automatic do_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int cyc, output int bcnt, output bit to);
        @(negedge clk);
        launch(m, x, y);
        wait_done(cyc, bcnt, to);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({busy, done, result, cout, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h cout=%b ovf=%b, expected all 0",
                     busy, done, result, cout, ovf);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    // One op against both the scoreboard and the literal values of the plan.
    task automatic test_op(input string name, input logic m, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] r_lit,
                           input logic c_lit, input logic o_lit);
        int   cyc, bcnt;
        bit   to;
        exp_t e;
        do_op(m, x, y, cyc, bcnt, to);
        e = sb.pop_front();
        n_run++;
        if (to) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within 40 cycles", name);
            return;
        end
        if ({result, cout, ovf} !== {e.res, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL %s_sb: got result=%h cout=%b ovf=%b, expected %h %b %b",
                     name, result, cout, ovf, e.res, e.cout, e.ovf);
        end
        n_run++;
        if ({result, cout, ovf} !== {r_lit, c_lit, o_lit}) begin
            n_fail++;
            $display("FAIL %s_value: got result=%h cout=%b ovf=%b, expected %h %b %b",
                     name, result, cout, ovf, r_lit, c_lit, o_lit);
        end
        n_run++;
        if (cyc !== 9 || bcnt !== 8) begin
            n_fail++;
            $display("FAIL %s_timing: got done_cycle=%0d busy_cycles=%0d, expected 9 8", name, cyc, bcnt);
        end
        @(negedge clk);
        n_run++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: got done=%b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic test_add();
        test_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        test_op("sub_05_03", 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        test_op("sub_03_05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        test_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        test_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        test_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    endtask

    task automatic test_start_while_busy();
        int   cyc, bcnt, extra;
        bit   to;
        exp_t e;
        @(negedge clk);
        launch(1'b0, 8'h10, 8'h20);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        wait_done(cyc, bcnt, to);
        e = sb.pop_front();
        n_run++;
        if (to || result !== e.res || result !== 8'h30 || cyc + 3 !== 9) begin
            n_fail++;
            $display("FAIL busy_start: got result=%h done_cycle=%0d timeout=%b, expected 30 9 0",
                     result, cyc + 3, to);
        end
        extra = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        n_run++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_no_second_op: got %0d busy/done cycles, expected 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        int   cyc, bcnt, extra;
        bit   to;
        exp_t e;
        @(negedge clk);
        launch(1'b0, 8'h12, 8'h34);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        void'(sb.pop_front());  // aborted op never reports
        @(negedge clk);
        n_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            n_fail++;
            $display("FAIL midop_reset: got busy=%b done=%b result=%h, expected 0 0 00", busy, done, result);
        end
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_run++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL midop_no_done: got %0d busy/done cycles after reset, expected 0", extra);
        end
        do_op(1'b0, 8'h01, 8'h01, cyc, bcnt, to);
        e = sb.pop_front();
        n_run++;
        if (to || result !== e.res || result !== 8'h02 || cyc !== 9) begin
            n_fail++;
            $display("FAIL midop_fresh: got result=%h done_cycle=%0d timeout=%b, expected 02 9 0",
                     result, cyc, to);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc, bcnt;
        bit   to;
        exp_t e;
        do_op(1'b0, 8'h22, 8'h11, cyc, bcnt, to);
        e = sb.pop_front();
        n_run++;
        if (to || result !== e.res) begin
            n_fail++;
            $display("FAIL b2b_first: got result=%h timeout=%b, expected %h 0", result, to, e.res);
        end
        // Still in the done cycle: request the next op immediately.
        launch(1'b1, 8'h0F, 8'h01);
        wait_done(cyc, bcnt, to);
        e = sb.pop_front();
        n_run++;
        if (bcnt !== 8) begin
            n_fail++;
            $display("FAIL b2b_busy: got %0d busy cycles, expected 8", bcnt);
        end
        n_run++;
        if (to || cyc !== 9 || {result, cout} !== {e.res, e.cout} || {result, cout} !== {8'h0E, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: got result=%h cout=%b done_cycle=%0d, expected 0e 0 9",
                     result, cout, cyc);
        end
    endtask

    task automatic test_random();
        int           cyc, bcnt;
        bit           to;
        exp_t         e;
        logic         m;
        logic [W-1:0] x, y;
        for (int i = 0; i < 24; i++) begin
            m = 1'($urandom_range(1));
            x = W'($urandom);
            y = W'($urandom);
            do_op(m, x, y, cyc, bcnt, to);
            e = sb.pop_front();
            n_run++;
            if (to || {result, cout, ovf} !== {e.res, e.cout, e.ovf}) begin
                n_fail++;
                $display("FAIL random_%0d: mode=%b a=%h b=%h got %h %b %b, expected %h %b %b",
                         i, m, x, y, result, cout, ovf, e.res, e.cout, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_start_while_busy();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, bit-serial two's-complement adder/subtractor.
- Processes one bit per clock, LSB first, through a single full-adder/full-subtractor cell. The carry or borrow is held in a flip-flop between bits.
- Uses a start/busy/done handshake. Successor to the single-bit combinational full subtractor: adds WIDTH generalisation, an add/sub mode, sequencing, and carry/borrow and signed-overflow flags.
- Intended as a low-area arithmetic unit for multi-cycle datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a new operation; sampled only when the block is idle or done
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); latched at accepted start
- a  input  WIDTH  first operand; latched at accepted start
- b  input  WIDTH  second operand; latched at accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: result and flags valid
- result  output  WIDTH  sum or difference; held until the next accepted start
- cout  output  1  carry-out (add) or borrow-out (sub) of the MSB
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: clock and reset are one clock `clk` with a synchronous, active-high reset `rst`.
  - Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0. Internal bit counter and carry/borrow flop are 0.
  - Reset has priority over everything, including mid-operation. An aborted operation produces no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches a, b and mode, clears the carry/borrow flop and the counter, and enters RUN.
  - busy is 1 from that edge.
  - start=0 keeps the block in IDLE.
- RUN: each edge processes bit i = counter, using the latched operands.
  - Add: s = a[i]^b[i]^c; c' = a[i]&b[i] | c&(a[i]^b[i]).
  - Sub: d = a[i]^b[i]^c; c' = ~a[i]&b[i] | c&~(a[i]^b[i]).
  - The bit is shifted into result from the MSB side, so after WIDTH shifts bit 0 sits at result[0]. result is not stable or valid while busy=1.
  - start is ignored in RUN.
  - After the edge processing bit WIDTH-1, go to DONE: busy=0, done=1, cout=final c', ovf valid.
- DONE:
  - Lasts exactly one cycle.
  - start=1 at the next edge is accepted as in IDLE (back-to-back). Otherwise the block goes to IDLE.
  - done returns to 0 either way. result, cout and ovf hold until the next accepted start, then are don't-care until the next done.
- Latency: start sampled at edge E0 gives done=1 in the cycle following edge E0+WIDTH. That is WIDTH+1 cycles per operation and a throughput of one operation per WIDTH+1 cycles.
- Overflow (from latched operands, MSB = WIDTH-1):
  - Add: ovf = (a[MSB]==b[MSB]) & (result[MSB]!=a[MSB]).
  - Sub: ovf = (a[MSB]!=b[MSB]) & (result[MSB]!=a[MSB]).
- Arithmetic: result is modulo 2^WIDTH. cout is the unsigned carry for add and the unsigned borrow (a<b) for sub.
- Operands changing on the inputs during RUN must not affect the result.

Test Plan (WIDTH=8):
- Add, mode=0, a=0x5A, b=0x3C, start pulsed one cycle -> busy high for 8 cycles; done=1 exactly 9 cycles after the start edge; result=0x96, cout=0, ovf=1.
- Sub, mode=1:
  - 0x05-0x03 -> result=0x02, cout=0, ovf=0.
  - 0x03-0x05 -> result=0xFE, cout=1, ovf=0.
  - 0x80-0x01 -> result=0x7F, cout=0, ovf=1.
- Add wrap: 0xFF+0x01 -> result=0x00, cout=1, ovf=0. Then 0x7F+0x01 -> result=0x80, cout=0, ovf=1.
- Start while busy: start 0x10+0x20, then at RUN cycle 3 change a/b to 0xAA/0x55 and pulse start again -> single done with result=0x30; no second operation begins.
- Reset mid-op: start 0x12+0x34, assert rst at RUN cycle 4 -> next cycle busy=0, done=0, result=0, and no done pulse follows. A fresh start of 0x01+0x01 then gives result=0x02 after 9 cycles.
- Back-to-back: hold start=1 with a new operand pair (0x0F-0x01) during the done cycle -> busy=1 in the following cycle, second done 9 cycles later with result=0x0E, cout=0.
